// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register carrying a control and
// a data bundle through STAGES back-to-back slots, each with a valid bit.
// Per falling edge the priority is reset > flush > stall > advance. A slot
// whose valid bit is clear always holds an all-zero control field, so a bubble
// can never enable a downstream write.
// Optional feature: define PIPE_PERF_CNT_EN to add the stall_cnt/bubble_cnt
// saturating performance counters and their ports.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 200,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
`ifdef PIPE_PERF_CNT_EN
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`else
  output logic [DATA_W-1:0] data_out
`endif
);

  logic              validQ [STAGES];
  logic [CTRL_W-1:0] ctrlQ  [STAGES];
  logic [DATA_W-1:0] dataQ  [STAGES];

  // Value each slot loads on an advancing edge: slot 0 from the inputs, slot k
  // from slot k-1. Indexing by k-1 for k>=1 keeps every index in range even
  // when STAGES is 1.
  logic              feedValid [STAGES];
  logic [CTRL_W-1:0] feedCtrl  [STAGES];
  logic [DATA_W-1:0] feedData  [STAGES];

  // Build slot input values; control is zeroed at entry for bubbles
  always_comb begin
    feedValid[0] = valid_in;
    feedCtrl[0]  = valid_in ? ctrl_in : '0;
    feedData[0]  = data_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      feedValid[k] = validQ[k-1];
      feedCtrl[k]  = ctrlQ[k-1];
      feedData[k]  = dataQ[k-1];
    end
  end

  // Slot registers: reset clears all, flush kills valid/ctrl, stall holds
  always_ff @(negedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        validQ[k] <= 1'b0;
        ctrlQ[k]  <= '0;
        dataQ[k]  <= '0;
      end
    end else if (flush) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        validQ[k] <= 1'b0;
        ctrlQ[k]  <= '0;
      end
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        validQ[k] <= feedValid[k];
        ctrlQ[k]  <= feedCtrl[k];
        dataQ[k]  <= feedData[k];
      end
    end
  end

  assign valid_out = validQ[STAGES-1];
  assign ctrl_out  = ctrlQ[STAGES-1];
  assign data_out  = dataQ[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] bubbleCnt;
  logic             lastGetsBubble;

  // The last slot is loaded with a bubble on any flush, or on an advance
  // whose feeding value is invalid; a stalled edge loads nothing.
  assign lastGetsBubble = flush || (!stall && !feedValid[STAGES-1]);

  // Saturating counters, cleared only by reset
  always_ff @(negedge clk) begin
    if (!reset) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (stall && (stallCnt != '1)) begin
        stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (lastGetsBubble && (bubbleCnt != '1)) begin
        bubbleCnt <= bubbleCnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt  = stallCnt;
  assign bubble_cnt = bubbleCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (STAGES = 1, 2, 3) share
// one set of inputs; each test checks the instance it targets. Counter checks
// are present only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

  logic         clk = 1'b1;
  logic         reset;
  logic         stall;
  logic         flush;
  logic         validIn;
  logic [8:0]   ctrlIn;
  logic [199:0] dataIn;

  logic         valid1, valid2, valid3;
  logic [8:0]   ctrl1, ctrl2, ctrl3;
  logic [199:0] data1, data2, data3;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]   stallCnt1, bubbleCnt1;
  logic [15:0]  stallCnt2, bubbleCnt2, stallCnt3, bubbleCnt3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(200), .STAGES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(validIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(valid1), .ctrl_out(ctrl1),
`ifdef PIPE_PERF_CNT_EN
    .data_out(data1), .stall_cnt(stallCnt1), .bubble_cnt(bubbleCnt1)
`else
    .data_out(data1)
`endif
  );

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(200), .STAGES(2), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(validIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(valid2), .ctrl_out(ctrl2),
`ifdef PIPE_PERF_CNT_EN
    .data_out(data2), .stall_cnt(stallCnt2), .bubble_cnt(bubbleCnt2)
`else
    .data_out(data2)
`endif
  );

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(200), .STAGES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_in(validIn), .ctrl_in(ctrlIn), .data_in(dataIn),
    .valid_out(valid3), .ctrl_out(ctrl3),
`ifdef PIPE_PERF_CNT_EN
    .data_out(data3), .stall_cnt(stallCnt3), .bubble_cnt(bubbleCnt3)
`else
    .data_out(data3)
`endif
  );

  function automatic logic [199:0] patData(input logic [7:0] b);
    return {25{b}};
  endfunction

  task automatic checkVal(input string tag, input logic [255:0] obs,
                          input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next falling (active) edge and settle
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    validIn = 1'b1;
    ctrlIn  = 9'h1FF;
    dataIn  = '1;

    // Reset held for two edges with live inputs
    step();
    step();
    checkVal("rst_valid3", 256'(valid3), 256'(0));
    checkVal("rst_ctrl3",  256'(ctrl3),  256'(0));
    checkVal("rst_data3",  256'(data3),  256'(0));
    checkVal("rst_valid1", 256'(valid1), 256'(0));
    checkVal("rst_ctrl1",  256'(ctrl1),  256'(0));
    checkVal("rst_data1",  256'(data1),  256'(0));

    // Latency stream: ctrl i presented before edge i
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ctrlIn = 9'(i);
      dataIn = patData(8'(i));
      step();
      checkVal("lat_ctrl1",  256'(ctrl1), 256'(i));
      checkVal("lat_valid3", 256'(valid3), 256'(i >= 3));
      checkVal("lat_ctrl3",  256'(ctrl3), (i >= 3) ? 256'(i - 2) : 256'(0));
      checkVal("lat_data3",  256'(data3),
               (i >= 3) ? 256'(patData(8'(i - 2))) : 256'(0));
      checkVal("lat_ctrl2",  256'(ctrl2), 256'(i - 1));
    end

    // Stall on STAGES=2: 5 then 6 in flight, 7 dropped while stalled
    reset = 1'b0;
    step();
    reset = 1'b1;
    ctrlIn = 9'd5; dataIn = patData(8'd5); step();
    ctrlIn = 9'd6; dataIn = patData(8'd6); step();
    checkVal("stl_pre_ctrl2", 256'(ctrl2), 256'(5));
    stall  = 1'b1;
    ctrlIn = 9'd7; dataIn = patData(8'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("stl_hold_ctrl2",  256'(ctrl2),  256'(5));
      checkVal("stl_hold_valid2", 256'(valid2), 256'(1));
    end
    stall  = 1'b0;
    ctrlIn = 9'd8; dataIn = patData(8'd8); step();
    checkVal("stl_rel_ctrl2", 256'(ctrl2), 256'(6));
    ctrlIn = 9'd9; dataIn = patData(8'd9); step();
    checkVal("stl_drop_ctrl2", 256'(ctrl2), 256'(8));

    // Flush with simultaneous stall: ctrl 9 at output, 0x041 behind it
    ctrlIn = 9'h041; dataIn = patData(8'h41); step();
    checkVal("fl_pre_ctrl2", 256'(ctrl2), 256'(9));
    checkVal("fl_pre_data2", 256'(data2), 256'(patData(8'd9)));
    flush = 1'b1;
    stall = 1'b1;
    step();
    checkVal("fl_valid2", 256'(valid2), 256'(0));
    checkVal("fl_ctrl2",  256'(ctrl2),  256'(0));
    checkVal("fl_data2",  256'(data2),  256'(patData(8'd9)));
    checkVal("fl_valid3", 256'(valid3), 256'(0));
    checkVal("fl_ctrl3",  256'(ctrl3),  256'(0));
    flush = 1'b0;
    stall = 1'b0;

    // Bubble insertion: invalid input with all-ones control
    validIn = 1'b0;
    ctrlIn  = 9'h1FF;
    dataIn  = patData(8'h3C);
    step();
    checkVal("bub_valid1", 256'(valid1), 256'(0));
    checkVal("bub_ctrl1",  256'(ctrl1),  256'(0));
    checkVal("bub_data1",  256'(data1),  256'(patData(8'h3C)));
    step();
    checkVal("bub_valid2", 256'(valid2), 256'(0));
    checkVal("bub_ctrl2",  256'(ctrl2),  256'(0));
    checkVal("bub_data2",  256'(data2),  256'(patData(8'h3C)));

    // Flush then resume: the first instruction after the flush is not lost
    validIn = 1'b1;
    flush   = 1'b1;
    step();
    flush  = 1'b0;
    ctrlIn = 9'h0A5; dataIn = patData(8'hA5);
    step();
    checkVal("res_ctrl1",  256'(ctrl1),  256'(9'h0A5));
    checkVal("res_valid2", 256'(valid2), 256'(0));
    step();
    checkVal("res_ctrl2",  256'(ctrl2),  256'(9'h0A5));

`ifdef PIPE_PERF_CNT_EN
    // Saturating counters on the CNT_W=4 instance
    reset = 1'b0;
    step();
    checkVal("cnt_rst_stall",  256'(stallCnt1),  256'(0));
    checkVal("cnt_rst_bubble", 256'(bubbleCnt1), 256'(0));
    reset   = 1'b1;
    validIn = 1'b1;
    stall   = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checkVal("cnt_stall_sat",   256'(stallCnt1),  256'(15));
    checkVal("cnt_bubble_zero", 256'(bubbleCnt1), 256'(0));
    stall = 1'b0;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) step();
    flush = 1'b0;
    step();
    checkVal("cnt_bubble_3",    256'(bubbleCnt1), 256'(3));
    checkVal("cnt_stall_keep",  256'(stallCnt1),  256'(15));
    reset = 1'b0;
    step();
    checkVal("cnt_clr_stall",  256'(stallCnt1),  256'(0));
    checkVal("cnt_clr_bubble", 256'(bubbleCnt1), 256'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that supersedes the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined MIPS datapath. It carries a control bundle and a data bundle through STAGES back-to-back register slots, with a per-slot valid bit, hold (stall) and kill (flush) controls, and bubble insertion that zeroes control fields so no downstream write is enabled. The hazard unit drives one instance between each pair of datapath stages.

## Interface
- CTRL_W, 9: width of control bundle (Jump, Branch*, MemRead, MemToReg, MemWrite, RegWrite packed by the instantiating stage)
- DATA_W, 200: width of data bundle (ALU result, operands, branch/jump targets, WriteReg, Zero, ...)
- STAGES, 1: number of register slots in series, legal 1..4
- CNT_W, 16: width of performance counters (only with PIPE_PERF_CNT_EN)

- clk  in  1  clock; all state updates on falling edge, as for every pipeline register in the datapath
- reset  in  1  synchronous, active-low; sampled on the falling edge of clk
- stall  in  1  hold: all slots keep contents
- flush  in  1  kill: all slots become bubbles
- valid_in  in  1  upstream slot holds a real instruction
- ctrl_in  in  CTRL_W  control bundle from upstream stage
- data_in  in  DATA_W  data bundle from upstream stage
- valid_out  out  1  valid bit of last slot
- ctrl_out  out  CTRL_W  control of last slot; all-zero whenever valid_out=0
- data_out  out  DATA_W  data of last slot
- stall_cnt  out  CNT_W  cycles with stall=1 (PIPE_PERF_CNT_EN only)
- bubble_cnt  out  CNT_W  bubbles emitted at output (PIPE_PERF_CNT_EN only)

## Operation
- Slot k (0..STAGES-1) holds {valid_k, ctrl_k, data_k}; slot 0 fed from inputs, slot k from slot k-1; outputs are slot STAGES-1 directly (registered, no combinational path from any input to any output).
- Per falling edge, priority reset > flush > stall > advance:
  - reset=0: all valid_k=0, ctrl_k=0, data_k=0; counters=0.
  - flush=1: all valid_k=0, ctrl_k=0; data_k unchanged. Flush overrides a simultaneous stall.
  - stall=1: every slot holds; valid_in/ctrl_in/data_in are dropped (upstream must also hold).
  - advance: slot 0 ← {valid_in, valid_in ? ctrl_in : 0, data_in}; slot k ← slot k-1.
- Bubble rule: a slot with valid=0 always has ctrl=0; data is don't-care but deterministic (captured value).
- No state machine beyond the slot shift; slots are independent flops with shared enable.
- Reset mid-stall or mid-flush: reset wins; next edge with reset=1 behaves normally.

## Timing
- Latency: STAGES falling edges from input to output when stall=0 throughout.
- Each stalled edge adds exactly one cycle of latency to every in-flight slot.
- Flush asserted at edge n: valid_out=0, ctrl_out=0 after edge n; the instruction presented at edge n+1 (if not stalled) reaches output STAGES edges later.
- Throughput: one instruction per non-stalled edge.
- All outputs 0 after reset until first valid instruction emerges.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cnt and bubble_cnt ports and logic present. stall_cnt increments on each edge with reset=1 and stall=1 (including edges where flush also set). bubble_cnt increments on each edge where slot STAGES-1 is loaded with valid=0 (advance of a bubble or flush). Both saturate at 2^CNT_W-1; cleared only by reset.
- Not defined: counter ports absent; no counter flops.

## Test plan
- Reset: hold reset=0 for 2 edges with valid_in=1, ctrl_in=9'h1FF, data_in all-ones -> valid_out=0, ctrl_out=0, data_out=0; release -> first capture on next edge.
- Latency, STAGES=3: stream valid_in=1, ctrl_in=1,2,3,… on consecutive edges -> ctrl_out=1 after edge 3, 2 after edge 4, no gaps.
- Stall: STAGES=2, inject ctrl 5 then 6, stall=1 for 3 edges while ctrl_in=7 -> outputs frozen at 5 for 3 edges, 7 never appears; ctrl 6 appears on first edge after release.
- Flush vs stall: valid_in=1, ctrl_in=9'h041 in flight, assert flush=1 and stall=1 same edge -> valid_out=0, ctrl_out=0 next edge, data_out unchanged.
- Bubble insertion: valid_in=0, ctrl_in=9'h1FF -> after latency valid_out=0, ctrl_out=0, data_out=data_in.
- Counters (macro on, CNT_W=4): 20 stalled edges -> stall_cnt=15 (saturated); 3 flushes -> bubble_cnt=3; reset -> both 0.
